// File: rtl/spi_reg_slave.sv
`timescale 1ns/1ps
// SPI mode-0 slave on osc_clk: each 32-bit frame shifts out the latest held sample
// and shifts in one command that may write one of NREGS 16-bit control registers.
module spi_reg_slave #(
    parameter int NREGS      = 8,
    parameter int FRAME_BITS = 32
) (
    input  logic                  osc_clk,
    input  logic                  rst_n,
    input  logic [FRAME_BITS-1:0] sample_in,
    input  logic                  sample_valid,
    input  logic                  SCK,
    input  logic                  SSEL,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic                  data_ready,
    output logic [16*NREGS-1:0]   Registers,
    output logic                  reg_wr_stb,
    output logic [7:0]            overrun_cnt
);

    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                state;
    logic [2:0]            sck_q;
    logic [2:0]            ssel_q;
    logic [1:0]            mosi_q;
    logic [FRAME_BITS-1:0] hold_reg;
    logic [FRAME_BITS-1:0] tx_sr;
    logic [FRAME_BITS-1:0] rx_sr;
    logic [CW-1:0]         bit_cnt;
    logic                  pending;

    logic sck_rise, sck_fall, ssel_fall, ssel_rise, mosi_s, load_cycle;

    // Synchronisers reset to the bus-idle levels so release creates no edge.
    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q  <= '0;
            ssel_q <= '1;
            mosi_q <= '0;
        end else begin
            sck_q  <= {sck_q[1:0], SCK};
            ssel_q <= {ssel_q[1:0], SSEL};
            mosi_q <= {mosi_q[0], MOSI};
        end
    end

    assign sck_rise   =  sck_q[1]  & ~sck_q[2];
    assign sck_fall   = ~sck_q[1]  &  sck_q[2];
    assign ssel_fall  = ~ssel_q[1] &  ssel_q[2];
    assign ssel_rise  =  ssel_q[1] & ~ssel_q[2];
    assign mosi_s     =  mosi_q[1];
    assign load_cycle = (state == IDLE) && ssel_fall;

    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hold_reg    <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            bit_cnt     <= '0;
            pending     <= 1'b0;
            Registers   <= '0;
            reg_wr_stb  <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            reg_wr_stb <= 1'b0;

            if (sample_valid)
                hold_reg <= sample_in;
            if (load_cycle)
                pending <= 1'b0;
            else if (sample_valid)
                pending <= 1'b1;
            if (sample_valid && pending && !load_cycle && (overrun_cnt != 8'hFF))
                overrun_cnt <= overrun_cnt + 8'd1;

            if (ssel_rise) begin
                // Only a frame that reached DONE may commit; short frames are dropped.
                if ((state == DONE) && rx_sr[FRAME_BITS-1]) begin
                    for (int unsigned n = 0; n < NREGS; n++) begin
                        if (rx_sr[FRAME_BITS-2 -: AW] == AW'(n))
                            Registers[16*n +: 16] <= rx_sr[15:0];
                    end
                    reg_wr_stb <= 1'b1;
                end
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (ssel_fall) begin
                            tx_sr   <= sample_valid ? sample_in : hold_reg;
                            bit_cnt <= '0;
                            state   <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (sck_rise) begin
                            rx_sr   <= {rx_sr[FRAME_BITS-2:0], mosi_s};
                            bit_cnt <= bit_cnt + CW'(1);
                            if (bit_cnt == LAST_BIT)
                                state <= DONE;
                        end
                        if (sck_fall)
                            tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
                    end
                    default: ;
                endcase
            end
        end
    end

    assign MISO       = (state == SHIFT) & tx_sr[FRAME_BITS-1];
    assign data_ready = pending;

endmodule

// File: tb/tb_spi_reg_slave.sv
`timescale 1ns/1ps
// Bench for spi_reg_slave: table of full frames plus hand-written corner sequences,
// with expected MISO words queued at stimulus time and popped when the frame ends.
module tb_spi_reg_slave;

    logic         osc_clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  sample_in = '0;
    logic         sample_valid = 1'b0;
    logic         SCK = 1'b0;
    logic         SSEL = 1'b1;
    logic         MOSI = 1'b0;
    logic         MISO;
    logic         data_ready;
    logic [127:0] Registers;
    logic         reg_wr_stb;
    logic [7:0]   overrun_cnt;

    int checks = 0;
    int failures = 0;
    int stb_cnt = 0;
    logic [31:0] exp_q[$];

    spi_reg_slave #(.NREGS(8), .FRAME_BITS(32)) dut (
        .osc_clk(osc_clk), .rst_n(rst_n), .sample_in(sample_in),
        .sample_valid(sample_valid), .SCK(SCK), .SSEL(SSEL), .MOSI(MOSI),
        .MISO(MISO), .data_ready(data_ready), .Registers(Registers),
        .reg_wr_stb(reg_wr_stb), .overrun_cnt(overrun_cnt)
    );

    always #5 osc_clk = ~osc_clk;

    always @(posedge osc_clk)
        if (reg_wr_stb) stb_cnt <= stb_cnt + 1;

    typedef struct {
        logic        do_sample;
        logic [31:0] sample;
        logic [31:0] cmd;
        logic [31:0] exp_miso;
        int          exp_stb;
        int          reg_idx;
        logic [15:0] exp_reg;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string name, input logic [31:0] word);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: got %0h expected <empty scoreboard>", name, word);
        end else begin
            check(name, word, exp_q.pop_front());
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge osc_clk);
    endtask

    task automatic offer(input logic [31:0] d);
        @(negedge osc_clk);
        sample_valid = 1'b1;
        sample_in    = d;
        @(negedge osc_clk);
        sample_valid = 1'b0;
    endtask

    task automatic spi_bit(input logic b, output logic m);
        MOSI = b;
        wait_neg(6);
        m = MISO;
        SCK = 1'b1;
        wait_neg(6);
        SCK = 1'b0;
    endtask

    task automatic run_frame(input logic [31:0] cmd, input int nbits, input logic byp,
                             input logic [31:0] byp_data, output logic [31:0] word);
        logic m;
        word = '0;
        @(negedge osc_clk);
        SSEL = 1'b0;
        if (byp) begin
            // Land sample_valid on the cycle the synchronised falling edge is acted on.
            @(posedge osc_clk);
            @(posedge osc_clk);
            @(negedge osc_clk);
            sample_valid = 1'b1;
            sample_in    = byp_data;
            @(negedge osc_clk);
            sample_valid = 1'b0;
        end
        for (int i = 0; i < nbits; i++) begin
            spi_bit(cmd[31-i], m);
            word = {word[30:0], m};
        end
        wait_neg(6);
        SSEL = 1'b1;
        wait_neg(10);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] word;
        logic        m;
        int          stb0;

        vecs[0] = '{1'b1, 32'hDEAD_BEEF, 32'h9000_1234, 32'hDEAD_BEEF, 1, 1, 16'h1234};
        vecs[1] = '{1'b0, 32'h0,         32'h7FFF_FFFF, 32'hDEAD_BEEF, 0, 7, 16'h0000};
        vecs[2] = '{1'b1, 32'hCAFE_0001, 32'hF000_ABCD, 32'hCAFE_0001, 1, 7, 16'hABCD};
        vecs[3] = '{1'b1, 32'h1234_5678, 32'h8000_FFFF, 32'h1234_5678, 1, 0, 16'hFFFF};
        vecs[4] = '{1'b1, 32'hA5A5_5A5A, 32'hA000_0042, 32'hA5A5_5A5A, 1, 2, 16'h0042};

        wait_neg(3);
        check("rst_miso", 128'(MISO), 128'd0);
        check("rst_data_ready", 128'(data_ready), 128'd0);
        check("rst_stb", 128'(reg_wr_stb), 128'd0);
        check("rst_registers", Registers, 128'd0);
        check("rst_overrun", 128'(overrun_cnt), 128'd0);
        rst_n = 1'b1;
        wait_neg(5);

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].do_sample) begin
                offer(vecs[i].sample);
                check($sformatf("v%0d_ready_set", i), 128'(data_ready), 128'd1);
            end
            stb0 = stb_cnt;
            exp_q.push_back(vecs[i].exp_miso);
            run_frame(vecs[i].cmd, 32, 1'b0, '0, word);
            sb_check($sformatf("v%0d_miso", i), word);
            check($sformatf("v%0d_stb", i), 128'(stb_cnt - stb0), 128'(vecs[i].exp_stb));
            check($sformatf("v%0d_reg", i), 128'(Registers[vecs[i].reg_idx*16 +: 16]),
                  128'(vecs[i].exp_reg));
            check($sformatf("v%0d_ready_clr", i), 128'(data_ready), 128'd0);
        end
        check("table_reg1_kept", 128'(Registers[16 +: 16]), 128'h1234);

        // Short frame: 20 bits only, must not write.
        stb0 = stb_cnt;
        run_frame(32'hF000_AAAA, 20, 1'b0, '0, word);
        check("short_reg7", 128'(Registers[112 +: 16]), 128'hABCD);
        check("short_stb", 128'(stb_cnt - stb0), 128'd0);

        // Bypass with a sample already pending: bypass word wins, no overrun.
        offer(32'h0BAD_F00D);
        check("byp_pre_ready", 128'(data_ready), 128'd1);
        stb0 = stb_cnt;
        exp_q.push_back(32'h0000_0055);
        run_frame(32'hC000_0077, 32, 1'b1, 32'h0000_0055, word);
        sb_check("byp_miso", word);
        check("byp_ready", 128'(data_ready), 128'd0);
        check("byp_overrun", 128'(overrun_cnt), 128'd0);
        check("byp_reg4", 128'(Registers[64 +: 16]), 128'h0077);
        check("byp_stb", 128'(stb_cnt - stb0), 128'd1);

        // Overrun: three unread samples, then the frame returns the last one.
        offer(32'h1111_0001);
        offer(32'h1111_0002);
        offer(32'h1111_0003);
        check("ovr_cnt2", 128'(overrun_cnt), 128'd2);
        exp_q.push_back(32'h1111_0003);
        run_frame(32'h0000_0000, 32, 1'b0, '0, word);
        sb_check("ovr_miso", word);
        check("ovr_ready_clr", 128'(data_ready), 128'd0);
        for (int i = 0; i < 300; i++)
            offer(32'h2000_0000 + 32'(i));
        check("ovr_sat", 128'(overrun_cnt), 128'd255);
        check("ovr_ready", 128'(data_ready), 128'd1);

        // Reset in the middle of a write frame.
        @(negedge osc_clk);
        SSEL = 1'b0;
        for (int i = 0; i < 16; i++) begin
            word = 32'hB000_5555;
            spi_bit(word[31-i], m);
        end
        @(negedge osc_clk);
        rst_n = 1'b0;
        @(negedge osc_clk);
        check("midrst_miso", 128'(MISO), 128'd0);
        check("midrst_ready", 128'(data_ready), 128'd0);
        check("midrst_stb", 128'(reg_wr_stb), 128'd0);
        check("midrst_registers", Registers, 128'd0);
        check("midrst_overrun", 128'(overrun_cnt), 128'd0);
        wait_neg(2);
        rst_n = 1'b1;
        stb0 = stb_cnt;
        wait_neg(6);
        SSEL = 1'b1;
        wait_neg(10);
        check("abort_stb", 128'(stb_cnt - stb0), 128'd0);
        check("abort_registers", Registers, 128'd0);
        exp_q.push_back(32'h0000_0000);
        run_frame(32'hB000_5555, 32, 1'b0, '0, word);
        sb_check("post_rst_miso", word);
        check("post_rst_reg3", 128'(Registers[48 +: 16]), 128'h5555);
        check("post_rst_stb", 128'(stb_cnt - stb0), 128'd1);
        check("sb_empty", 128'(exp_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
